// File: rtl/wb_rr_bus_arbiter.sv
// Round-robin shared-bus Wishbone interconnect: NUM_M masters onto one bus decoded
// to NUM_S slaves, with an unmapped-address error and a stall watchdog.
module wb_rr_bus_arbiter #(
    parameter int unsigned NUM_M = 3,
    parameter int unsigned NUM_S = 4,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned DEC_LSB = 8,
    parameter int unsigned DEC_W = 4,
    parameter logic [NUM_S*DEC_W-1:0] SLAVE_ID = {4'h4, 4'h3, 4'h1, 4'h5},
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*AW-1:0]     m_addr_i,
    input  logic [NUM_M*DW-1:0]     m_wdata_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    output logic [NUM_M*DW-1:0]     m_rdata_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [NUM_S-1:0]        s_cyc_o,
    output logic [NUM_S-1:0]        s_stb_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_addr_o,
    output logic [DW-1:0]           s_wdata_o,
    output logic [DW/8-1:0]         s_sel_o,
    input  logic [NUM_S*DW-1:0]     s_rdata_i,
    input  logic [NUM_S-1:0]        s_ack_i,
    output logic [NUM_M-1:0]        grant_o
);
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned MIW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned SIW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int unsigned WDW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [MIW-1:0] LAST_RST = MIW'(NUM_M - 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [MIW-1:0]   gidx_q, gidx_d;
    logic [MIW-1:0]   last_q, last_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic             err_pend_q, err_pend_d;
    logic             uerr_q, uerr_d;

    logic             own, g_cyc, g_stb, g_we;
    logic [AW-1:0]    g_addr;
    logic [DW-1:0]    g_wdata;
    logic [SW-1:0]    g_sel;
    logic [NUM_S-1:0] hit;
    logic             any_hit;
    logic [SIW-1:0]   sidx;
    logic             ack_sel, wd_fire, resp_err;
    logic             arb_found;
    logic [MIW-1:0]   arb_idx, cand;

    always_comb begin
        own     = (state_q == OWN);
        g_cyc   = own & m_cyc_i[gidx_q];
        g_stb   = g_cyc & m_stb_i[gidx_q];
        g_we    = m_we_i[gidx_q];
        g_addr  = m_addr_i[gidx_q*AW +: AW];
        g_wdata = m_wdata_i[gidx_q*DW +: DW];
        g_sel   = m_sel_i[gidx_q*SW +: SW];
    end

    // Lowest matching decode entry wins, so hit is always one-hot or zero.
    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        sidx    = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (!any_hit && g_addr[DEC_LSB +: DEC_W] == SLAVE_ID[k*DEC_W +: DEC_W]) begin
                hit[k]  = 1'b1;
                any_hit = 1'b1;
                sidx    = SIW'(k);
            end
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = MIW'((int'(last_q) + i) % NUM_M);
            if (!arb_found && m_cyc_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // An ack in the timeout cycle takes precedence over the watchdog error.
    always_comb begin
        ack_sel  = g_cyc & any_hit & s_ack_i[sidx];
        wd_fire  = g_stb & any_hit & ~ack_sel & (wdog_q == WD_LAST);
        resp_err = ((uerr_q & g_cyc) | wd_fire) & ~ack_sel;
    end

    always_comb begin
        s_cyc_o   = g_cyc ? hit : '0;
        s_stb_o   = g_stb ? hit : '0;
        s_we_o    = own & g_we;
        s_addr_o  = own ? g_addr : '0;
        s_wdata_o = own ? g_wdata : '0;
        s_sel_o   = own ? g_sel : '0;
        m_ack_o   = ack_sel ? grant_q : '0;
        m_err_o   = resp_err ? grant_q : '0;
        m_rdata_o = '0;
        if (g_cyc && any_hit) begin
            m_rdata_o[gidx_q*DW +: DW] = s_rdata_i[sidx*DW +: DW];
        end
        grant_o   = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d          = OWN;
                    gidx_d           = arb_idx;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                end
            end
            OWN: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: state_d = IDLE;
        endcase
        wdog_d     = (g_stb && any_hit && !ack_sel && wdog_q != WD_LAST) ? wdog_q + 1'b1 : '0;
        err_pend_d = g_stb & ~any_hit;
        uerr_d     = g_stb & ~any_hit & ~err_pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= LAST_RST;
            wdog_q     <= '0;
            err_pend_q <= 1'b0;
            uerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            err_pend_q <= err_pend_d;
            uerr_q     <= uerr_d;
        end
    end
endmodule
